// File: rtl/wb_master_queued_if.sv
// Wishbone classic bus bundle between the queued master and the interconnect.
// Signal names keep the master-side _o/_i suffixes so both ends read the same.
interface wb_master_queued_if #(
  parameter int DATA_WL = 32,
  parameter int ADR_WL  = 16
);
  localparam int SEL_WL = DATA_WL / 8;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [SEL_WL-1:0] wb_sel_o;
  logic [ADR_WL-1:0] wb_adr_o;
  logic [DATA_WL-1:0] wb_dat_o;
  logic              wb_ack_i;
  logic              wb_err_i;
  logic [DATA_WL-1:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_dat_i
  );
endinterface

// File: rtl/wb_master_queued.sv
// Queued Wishbone classic master: chip-side commands are buffered in a small
// FIFO and issued one at a time as single bus cycles. Each command ends in
// ACK, ERR or a timeout and returns exactly one response pulse, in order.
module wb_master_queued #(
  parameter int DATA_WL   = 32,
  parameter int ADR_WL    = 16,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset_h,
  wb_master_queued_if.master    wb,
  input  logic                  start_i,
  input  logic                  we_i,
  input  logic [ADR_WL-1:0]     addr_i,
  input  logic [DATA_WL-1:0]    data_i,
  input  logic [DATA_WL/8-1:0]  sel_i,
  output logic                  full_o,
  output logic                  drop_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [1:0]            status_o,
  output logic [DATA_WL-1:0]    data_o
);

  localparam int SEL_WL = DATA_WL / 8;
  localparam int PTR_WL = $clog2(CMD_DEPTH);
  localparam int CNT_WL = PTR_WL + 1;
  localparam logic [CNT_WL-1:0] DEPTH_CNT = CNT_WL'(CMD_DEPTH);
  // Timeout fires in the cycle the counter reaches TIMEOUT-1, so the strobe
  // stays up for exactly TIMEOUT cycles.
  localparam bit          TMO_EN   = (TIMEOUT > 0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  typedef struct packed {
    logic               we;
    logic [SEL_WL-1:0]  sel;
    logic [ADR_WL-1:0]  adr;
    logic [DATA_WL-1:0] dat;
  } cmd_t;

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t              mem [CMD_DEPTH];
  cmd_t              cmd_in;
  cmd_t              head;
  logic [PTR_WL-1:0] wr_ptr;
  logic [PTR_WL-1:0] rd_ptr;
  logic [CNT_WL-1:0] count;
  logic [CNT_WL-1:0] count_nxt;
  logic              push;
  logic              pop;

  // A full FIFO refuses the push even if the head is popped in the same cycle;
  // the refusal is what drop_o reports.
  assign push      = start_i && !full_o;
  assign cmd_in    = '{we: we_i, sel: sel_i, adr: addr_i, dat: data_i};
  assign head      = mem[rd_ptr];
  assign count_nxt = count + CNT_WL'(push) - CNT_WL'(pop);

  // Command storage write port.
  // NOTE: the storage array is deliberately not reset; entries are only read
  // after being written, and reset only has to clear the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // FIFO pointers, occupancy and the registered full/drop flags.
  // NOTE: every sequential assignment uses <= so all registers update from the
  // same pre-edge values; = here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WL'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WL'(1);
      count  <= count_nxt;
      full_o <= (count_nxt == DEPTH_CNT);
      drop_o <= start_i && full_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus sequencer
  // ---------------------------------------------------------------------------
  state_t              state;
  state_t              state_nxt;
  logic [15:0]         tmo_cnt;
  logic [15:0]         tmo_cnt_nxt;
  logic                tmo_hit;

  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [SEL_WL-1:0]   sel_q;
  logic [ADR_WL-1:0]   adr_q;
  logic [DATA_WL-1:0]  dat_q;

  logic                cyc_nxt;
  logic                stb_nxt;
  logic                we_nxt;
  logic [SEL_WL-1:0]   sel_nxt;
  logic [ADR_WL-1:0]   adr_nxt;
  logic [DATA_WL-1:0]  dat_nxt;
  logic                valid_nxt;
  logic [1:0]          status_nxt;
  logic [DATA_WL-1:0]  data_nxt;

  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

  // Next state, next bus outputs and the response for the current cycle.
  // NOTE: every variable gets a default before the case statement; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    pop         = 1'b0;
    cyc_nxt     = cyc_q;
    stb_nxt     = stb_q;
    we_nxt      = we_q;
    sel_nxt     = sel_q;
    adr_nxt     = adr_q;
    dat_nxt     = dat_q;
    valid_nxt   = 1'b0;
    status_nxt  = status_o;
    data_nxt    = data_o;

    unique case (state)
      IDLE: begin
        cyc_nxt = 1'b0;
        stb_nxt = 1'b0;
        we_nxt  = 1'b0;
        // Late ACK/ERR seen here belong to nobody and are ignored.
        if (count != '0) begin
          pop         = 1'b1;
          cyc_nxt     = 1'b1;
          stb_nxt     = 1'b1;
          we_nxt      = head.we;
          sel_nxt     = head.sel;
          adr_nxt     = head.adr;
          dat_nxt     = head.dat;
          tmo_cnt_nxt = '0;
          state_nxt   = BUS;
        end
      end

      BUS: begin
        if (wb.wb_err_i || wb.wb_ack_i || tmo_hit) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
          we_nxt    = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
          if (wb.wb_err_i) begin
            status_nxt = ST_ERR;
          end else if (wb.wb_ack_i) begin
            status_nxt = ST_OK;
            if (!we_q) data_nxt = wb.wb_dat_i;
          end else begin
            status_nxt = ST_TMO;
          end
        end else if (tmo_cnt != '1) begin
          tmo_cnt_nxt = tmo_cnt + 16'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State register plus all registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset_h) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      valid_o  <= 1'b0;
      status_o <= '0;
      data_o   <= '0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      cyc_q    <= cyc_nxt;
      stb_q    <= stb_nxt;
      we_q     <= we_nxt;
      sel_q    <= sel_nxt;
      adr_q    <= adr_nxt;
      dat_q    <= dat_nxt;
      valid_o  <= valid_nxt;
      status_o <= status_nxt;
      data_o   <= data_nxt;
      busy_o   <= (count_nxt != '0) || (state_nxt == BUS);
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_master_queued.sv
// Bench for wb_master_queued: directed scenarios plus a random phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_wb_master_queued;

  localparam int DATA_WL   = 32;
  localparam int ADR_WL    = 16;
  localparam int SEL_WL    = DATA_WL / 8;
  localparam int CMD_DEPTH = 4;
  localparam int TIMEOUT   = 8;

  logic               clk = 1'b0;
  logic               reset_h;
  logic               start_i;
  logic               we_i;
  logic [ADR_WL-1:0]  addr_i;
  logic [DATA_WL-1:0] data_i;
  logic [SEL_WL-1:0]  sel_i;
  logic               full_o;
  logic               drop_o;
  logic               busy_o;
  logic               valid_o;
  logic [1:0]         status_o;
  logic [DATA_WL-1:0] data_o;

  wb_master_queued_if #(.DATA_WL(DATA_WL), .ADR_WL(ADR_WL)) wb ();

  wb_master_queued #(
    .DATA_WL(DATA_WL), .ADR_WL(ADR_WL), .CMD_DEPTH(CMD_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_h(reset_h), .wb(wb),
    .start_i(start_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
    .full_o(full_o), .drop_o(drop_o), .busy_o(busy_o), .valid_o(valid_o),
    .status_o(status_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                 we;
    logic [ADR_WL-1:0]  adr;
    logic [DATA_WL-1:0] dat;
    logic [SEL_WL-1:0]  sel;
  } cmd_t;

  // Slave behaviour for one bus cycle: respond on strobe cycle 'at' (1-based),
  // 0 means never respond.
  typedef struct {
    int                 at;
    bit                 ack;
    bit                 err;
    logic [DATA_WL-1:0] rdata;
  } plan_t;

  cmd_t  cmd_q[$];
  plan_t plan_q[$];
  cmd_t  cur;
  plan_t cur_plan;

  bit                 m_stb, m_we, m_full, m_busy, m_valid, m_drop;
  int                 stb_cnt;
  logic [1:0]         m_status;
  logic [DATA_WL-1:0] m_data, m_wdat;
  logic [ADR_WL-1:0]  m_adr;
  logic [SEL_WL-1:0]  m_sel;

  bit   d_start, d_rst, d_stray;
  cmd_t d_cmd;

  int n_pass, n_checks, cyc_no;
  int n_valid, n_drop, stb_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    else n_pass++;
  endtask

  task automatic model_reset();
    cmd_q.delete();
    plan_q.delete();
    m_stb = 0; m_we = 0; m_full = 0; m_busy = 0; m_valid = 0; m_drop = 0;
    stb_cnt = 0; m_status = '0; m_data = '0; m_wdat = '0; m_adr = '0; m_sel = '0;
  endtask

  function automatic plan_t rand_plan();
    plan_t p;
    int k;
    k = int'($urandom_range(0, 3));
    p.at    = int'($urandom_range(0, 10));
    p.ack   = (k != 1);
    p.err   = (k == 1) || (k == 2);
    p.rdata = $urandom;
    return p;
  endfunction

  // One clock cycle: drive inputs, let the edge happen, advance the model by
  // what the edge should have done, then compare every output.
  task automatic cycle();
    bit                 a_ack, a_err, a_start, a_rst, was_full, term;
    logic [DATA_WL-1:0] a_dat;
    cmd_t               a_cmd;

    a_ack = 0; a_err = 0; a_dat = $urandom;
    if (m_stb && cur_plan.at == stb_cnt) begin
      a_ack = cur_plan.ack; a_err = cur_plan.err; a_dat = cur_plan.rdata;
    end else if (!m_stb && d_stray) begin
      a_ack = ($urandom_range(0, 2) == 0);
    end
    a_start = d_start; a_rst = d_rst; a_cmd = d_cmd;

    reset_h = a_rst; start_i = a_start;
    we_i = a_cmd.we; addr_i = a_cmd.adr; data_i = a_cmd.dat; sel_i = a_cmd.sel;
    wb.wb_ack_i = a_ack; wb.wb_err_i = a_err; wb.wb_dat_i = a_dat;

    @(posedge clk);
    @(negedge clk);
    cyc_no++;

    if (a_rst) begin
      model_reset();
    end else begin
      was_full = m_full;
      m_valid  = 0;
      m_drop   = a_start && was_full;
      if (m_stb) begin
        term = 1;
        if (a_err) m_status = 2'b01;
        else if (a_ack) begin
          m_status = 2'b00;
          if (!cur.we) m_data = a_dat;
        end else if (TIMEOUT != 0 && stb_cnt == TIMEOUT) m_status = 2'b10;
        else term = 0;
        if (term) begin
          m_valid = 1; m_stb = 0; m_we = 0;
        end else begin
          stb_cnt++;
        end
      end else if (cmd_q.size() > 0) begin
        cur      = cmd_q.pop_front();
        cur_plan = (plan_q.size() > 0) ? plan_q.pop_front() : rand_plan();
        m_stb = 1; stb_cnt = 1;
        m_we = cur.we; m_adr = cur.adr; m_wdat = cur.dat; m_sel = cur.sel;
      end
      if (a_start && !was_full) cmd_q.push_back(a_cmd);
      m_full = (cmd_q.size() == CMD_DEPTH);
      m_busy = (cmd_q.size() > 0) || m_stb;
    end

    check("cyc",    wb.wb_cyc_o, m_stb);
    check("stb",    wb.wb_stb_o, m_stb);
    check("we",     wb.wb_we_o,  m_we);
    check("adr",    wb.wb_adr_o, m_adr);
    check("wdat",   wb.wb_dat_o, m_wdat);
    check("sel",    wb.wb_sel_o, m_sel);
    check("valid",  valid_o,  m_valid);
    check("status", status_o, m_status);
    check("data",   data_o,   m_data);
    check("full",   full_o,   m_full);
    check("busy",   busy_o,   m_busy);
    check("drop",   drop_o,   m_drop);

    if (valid_o)      n_valid++;
    if (drop_o)       n_drop++;
    if (wb.wb_stb_o)  stb_cycles++;
  endtask

  task automatic push(input bit we, input logic [ADR_WL-1:0] a,
                      input logic [DATA_WL-1:0] d, input logic [SEL_WL-1:0] s);
    d_start = 1;
    d_cmd.we = we; d_cmd.adr = a; d_cmd.dat = d; d_cmd.sel = s;
    cycle();
    d_start = 0;
  endtask

  task automatic wait_stb(input string tag, input int limit);
    int k = 0;
    while (!wb.wb_stb_o && k < limit) begin cycle(); k++; end
    check({tag, "_stb_seen"}, wb.wb_stb_o, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int k = 0;
    while (!valid_o && k < limit) begin cycle(); k++; end
    check({tag, "_valid_seen"}, valid_o, 1'b1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((busy_o || m_busy) && k < 300) begin cycle(); k++; end
    check({tag, "_drained"}, busy_o, 1'b0);
    cycle();
  endtask

  initial begin
    int                 t_push, t_stb;
    logic [DATA_WL-1:0] saved;

    n_pass = 0; n_checks = 0; cyc_no = 0;
    n_valid = 0; n_drop = 0; stb_cycles = 0;
    d_start = 0; d_rst = 1; d_stray = 0;
    d_cmd.we = 0; d_cmd.adr = '0; d_cmd.dat = '0; d_cmd.sel = '0;
    model_reset();

    // Reset: two cycles, every output must read zero.
    cycle(); cycle();
    d_rst = 0;
    check("rst_data",   data_o,   '0);
    check("rst_status", status_o, '0);
    cycle();

    // Single read, slave ACKs on the 3rd strobe cycle.
    plan_q.push_back('{3, 1'b1, 1'b0, 32'hDEAD_BEEF});
    t_push = cyc_no;
    push(1'b0, 16'h0010, 32'h0, 4'hF);
    wait_stb("rd", 10);
    t_stb = cyc_no;
    check("rd_stb_latency", 64'(t_stb - t_push), 64'd2);
    wait_valid("rd", 10);
    check("rd_ack_latency", 64'(cyc_no - t_stb), 64'd3);
    check("rd_status", status_o, 2'b00);
    check("rd_data",   data_o,   32'hDEAD_BEEF);
    check("rd_cyc_low", wb.wb_cyc_o, 1'b0);
    drain("rd");

    // Queue fill against a stalled slave: the sixth back-to-back push finds
    // the FIFO full (one entry already left for the bus) and is dropped.
    for (int i = 0; i < 5; i++) plan_q.push_back('{6, 1'b1, 1'b0, $urandom});
    n_drop = 0; n_valid = 0;
    for (int i = 0; i < 6; i++) push(1'b0, ADR_WL'(16'h0100 + i), $urandom, 4'hF);
    drain("fill");
    check("fill_drops",  64'(n_drop),  64'd1);
    check("fill_valids", 64'(n_valid), 64'd5);

    // Error with ACK and ERR together on a write: ERR wins, data_o untouched.
    saved = data_o;
    plan_q.push_back('{2, 1'b1, 1'b1, 32'h1234_5678});
    push(1'b1, 16'h0020, 32'hCAFE_F00D, 4'hF);
    wait_valid("err", 12);
    check("err_status", status_o, 2'b01);
    check("err_data_held", data_o, saved);
    drain("err");

    // Timeout: no response, strobe high for exactly TIMEOUT cycles.
    plan_q.push_back('{0, 1'b0, 1'b0, 32'h0});
    stb_cycles = 0;
    push(1'b0, 16'h0030, 32'h0, 4'hF);
    wait_valid("tmo", 30);
    check("tmo_stb_cycles", 64'(stb_cycles), 64'(TIMEOUT));
    check("tmo_status", status_o, 2'b10);
    d_stray = 1; n_valid = 0;
    repeat (6) cycle();
    d_stray = 0;
    check("stray_ack_ignored", 64'(n_valid), 64'd0);

    // Byte selects and write data on the bus.
    plan_q.push_back('{1, 1'b1, 1'b0, 32'h0});
    push(1'b1, 16'h0040, 32'h0000_A5A5, 4'h3);
    wait_stb("sel", 10);
    check("sel_bus",  wb.wb_sel_o, 4'h3);
    check("sel_wdat", wb.wb_dat_o, 32'h0000_A5A5);
    check("sel_we",   wb.wb_we_o,  1'b1);
    wait_valid("sel", 10);
    check("sel_status", status_o, 2'b00);
    drain("sel");

    // Reset while the first of two queued commands is on the bus.
    plan_q.push_back('{0, 1'b0, 1'b0, 32'h0});
    plan_q.push_back('{0, 1'b0, 1'b0, 32'h0});
    push(1'b0, 16'h0050, 32'h0, 4'hF);
    push(1'b1, 16'h0054, 32'h1111_2222, 4'hF);
    wait_stb("mid", 10);
    d_rst = 1;
    cycle();
    d_rst = 0;
    check("mid_busy",  busy_o,      1'b0);
    check("mid_cyc",   wb.wb_cyc_o, 1'b0);
    check("mid_valid", valid_o,     1'b0);
    n_valid = 0;
    repeat (15) cycle();
    check("mid_no_response", 64'(n_valid), 64'd0);

    // Random traffic with random slave behaviour and stray ACKs when idle.
    d_stray = 1;
    for (int i = 0; i < 800; i++) begin
      d_start   = ($urandom_range(0, 4) < 2);
      d_cmd.we  = $urandom_range(0, 1) == 1;
      d_cmd.adr = ADR_WL'($urandom);
      d_cmd.dat = $urandom;
      d_cmd.sel = SEL_WL'($urandom);
      cycle();
    end
    d_start = 0;
    drain("rand");
    d_stray = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
